spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
  - clk: input, 1 bit, the single system clock.
  - reset: input, 1 bit, synchronous, active-high.
REQ-002 The remaining ports SHALL be:
  - sclk: input, 1 bit, SPI clock from the host; asynchronous to clk.
  - cs_n: input, 1 bit, SPI chip select, active-low; asynchronous.
  - mosi: input, 1 bit, SPI data from the host; asynchronous.
  - miso: output, 1 bit, SPI data to the host.
  - miso_oe: output, 1 bit, miso output enable for the pad tristate.
  - reg_addr: output, 7 bits, register address for the current access.
  - wr_en: output, 1 bit, single-cycle register write strobe.
  - wr_data: output, 8 bits, register write data; drives the config register data_in.
  - rd_en: output, 1 bit, single-cycle register read strobe.
  - rd_data: input, 8 bits, register read data; connected to the config register data_out.
  - frame_err: output, 1 bit, single-cycle pulse on an aborted or short frame.

Function
REQ-003 The SPI protocol SHALL be mode 0 (CPOL=0, CPHA=0), MSB first:
  - mosi is sampled on sclk rising edges.
  - miso changes on sclk falling edges.
REQ-004 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; sclk edges and cs_n edges are detected on clk from the synchronized values. Supported sclk frequency is at most clk/8.
REQ-005 The frame format SHALL be 16 bits while cs_n is low:
  - bit15 = R/W (1 = read).
  - bits14:8 = address.
  - bits7:0 = data (write) or don't-care (read).
REQ-006 The FSM SHALL have the states IDLE, CMD, RD_FETCH, RD_SHIFT, WR_SHIFT and DONE.
REQ-007 IDLE -> CMD on a cs_n falling edge; the bit counter clears to 0.
REQ-008 CMD SHALL shift in 8 bits. On the 8th rising edge:
  - reg_addr is loaded.
  - If R/W=1, the FSM goes to RD_FETCH.
  - Otherwise it goes to WR_SHIFT.
REQ-009 RD_FETCH SHALL run as follows:
  - Cycle 1: assert rd_en for exactly one clk.
  - Cycle 2 (the cycle after rd_en): capture rd_data into the tx shift register.
  - Then go to RD_SHIFT.
REQ-010 RD_SHIFT SHALL drive bit 7 of the tx shift register on the next sclk falling edge, then bits 6..0 on the following falling edges.
REQ-011 WR_SHIFT SHALL shift in 8 bits. On the 16th rising edge, the next clk cycle asserts wr_en for one clk, with wr_data and reg_addr stable that cycle. The FSM then goes to DONE.
REQ-012 DONE SHALL ignore further sclk edges until cs_n rises, then return to IDLE.
REQ-013 When extra bits arrive beyond 16, no strobe is generated and miso = 0.
REQ-014 miso_oe SHALL be 1 only while the synchronized cs_n is low. miso SHALL be 0 outside RD_SHIFT.
REQ-015 A cs_n rising edge in CMD, RD_FETCH, RD_SHIFT or WR_SHIFT before bit 16 SHALL:
  - abort the frame;
  - suppress wr_en;
  - pulse frame_err for one clk;
  - return the FSM to IDLE.
  A read that completes 16 bits is not an error.
REQ-016 wr_en and rd_en SHALL never be asserted in the same cycle, and each SHALL assert at most once per frame.
REQ-017 The bit counter SHALL be 5 bits and saturate at 16; it SHALL never wrap.
REQ-018 A cs_n falling edge while in DONE SHALL not occur without an intervening rise. A new falling edge coincident with the abort cycle SHALL be honoured: the FSM goes to CMD on the next cycle.

Reset
REQ-019 On reset the block SHALL set:
  - FSM = IDLE; bit counter = 0; shift registers = 0.
  - reg_addr = 0, wr_data = 0.
  - wr_en = 0, rd_en = 0, frame_err = 0.
  - miso = 0, miso_oe = 0.
  - Synchronizer flops: sclk = 0, cs_n = 1, mosi = 0.
REQ-020 Reset asserted mid-frame SHALL discard the frame without any strobe. After reset releases, the block SHALL wait in IDLE for a fresh cs_n falling edge, even if cs_n is already low.

Structure
REQ-021 A shared package audio_gain_pkg SHALL hold:
  - the FSM state enum;
  - SPI_FRAME_BITS=16, SPI_ADDR_W=7, SPI_DATA_W=8;
  - SYNC_STAGES=2;
  - the address constant AUDIO_GAIN_CFG_ADDR=7'h00.
REQ-022 One sub-module, sync_edge, SHALL implement the 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses the synchronizer only.

Verification
REQ-023 Write frame 0x00_15 at sclk=clk/8 -> exactly one wr_en, with reg_addr=0x00 and wr_data=0x15. rd_en stays 0 and frame_err stays 0.
REQ-024 Read frame 0x80_xx, with rd_data=0xA5 held only the cycle after rd_en -> rd_en pulses once after the 8th rising edge, and the host samples 0xA5 on miso (MSB first) on bits 8..15.
REQ-025 Write 0x00_15, then read 0x80 back through the audio_gain config register -> the host receives 0x15.
REQ-026 cs_n rises after 11 bits of a write 0x00_FF -> no wr_en, one frame_err pulse, FSM returns to IDLE. The following write 0x00_01 completes normally.
REQ-027 20-bit write frame 0x00_3C plus 4 extra bits -> exactly one wr_en with 0x3C, and miso=0 throughout.
REQ-028 Reset pulsed during bit 12 of a write 0x00_7F -> no wr_en, and all outputs are at their reset values the cycle after reset.

Source files
------------

// File: rtl/audio_gain_pkg.sv
// Shared constants and FSM state type for the SPI register bridge feeding
// the audio_gain configuration register.
package audio_gain_pkg;
    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_ADDR_W     = 7;
    localparam int SPI_DATA_W     = 8;
    localparam int SYNC_STAGES    = 2;
    localparam int BIT_CNT_W      = 5;

    localparam logic [SPI_ADDR_W-1:0] AUDIO_GAIN_CFG_ADDR = 7'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_FETCH,
        RD_SHIFT,
        WR_SHIFT,
        DONE
    } spi_state_t;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses; pulses are held off until
// the chain and the edge-history flop carry real samples after reset.
module sync_edge
    import audio_gain_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [SYNC_STAGES:0]   settle_reg;
    logic                   settled;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg   <= {SYNC_STAGES{RESET_VAL}};
            prev_reg   <= RESET_VAL;
            settle_reg <= '0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg   <= sync_reg[SYNC_STAGES-1];
            settle_reg <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Without the settle gate a pin already away from RESET_VAL would look
    // like a fresh edge right after reset.
    assign settled = settle_reg[SYNC_STAGES];
    assign dout    = sync_reg[SYNC_STAGES-1];
    assign rise    = settled &  dout & ~prev_reg;
    assign fall    = settled & ~dout &  prev_reg;
endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames (R/W, 7-bit address, 8-bit data)
// into single-cycle register read/write strobes on the clk domain.
module spi_reg_bridge
    import audio_gain_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [SPI_ADDR_W-1:0] reg_addr,
    output logic                  wr_en,
    output logic [SPI_DATA_W-1:0] wr_data,
    output logic                  rd_en,
    input  logic [SPI_DATA_W-1:0] rd_data,
    output logic                  frame_err
);
    localparam logic [BIT_CNT_W-1:0] CNT_MAX    = BIT_CNT_W'(SPI_FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] CMD_LAST   = BIT_CNT_W'(SPI_FRAME_BITS - SPI_DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] FRAME_LAST = BIT_CNT_W'(SPI_FRAME_BITS - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic mosi_s;

    spi_state_t            state_reg, state_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next, bit_cnt_inc;
    logic [SPI_DATA_W-2:0] rx_reg, rx_next;
    logic [SPI_DATA_W-1:0] tx_reg, tx_next;
    logic [SPI_ADDR_W-1:0] addr_reg, addr_next;
    logic [SPI_DATA_W-1:0] wdata_reg, wdata_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  fetch_phase_reg, fetch_phase_next;
    logic                  miso_reg, miso_next;

    sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .reset(reset),
        .din  (sclk),
        .dout (sclk_level_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .reset(reset),
        .din  (cs_n),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi goes through the same depth as sclk so a detected rise samples
    // the bit that was on the wire at the real sclk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    assign bit_cnt_inc = (bit_cnt_reg == CNT_MAX) ? CNT_MAX : bit_cnt_reg + BIT_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            rx_reg          <= '0;
            tx_reg          <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wr_en_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
            fetch_phase_reg <= 1'b0;
            miso_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            rx_reg          <= rx_next;
            tx_reg          <= tx_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            wr_en_reg       <= wr_en_next;
            frame_err_reg   <= frame_err_next;
            fetch_phase_reg <= fetch_phase_next;
            miso_reg        <= miso_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        rx_next          = rx_reg;
        tx_next          = tx_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        wr_en_next       = 1'b0;
        frame_err_next   = 1'b0;
        fetch_phase_next = fetch_phase_reg;
        miso_next        = miso_reg;

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next   = CMD;
                    bit_cnt_next = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else if (sclk_rise) begin
                    rx_next      = {rx_reg[SPI_DATA_W-3:0], mosi_s};
                    bit_cnt_next = bit_cnt_inc;
                    if (bit_cnt_reg == CMD_LAST) begin
                        addr_next        = {rx_reg[SPI_ADDR_W-2:0], mosi_s};
                        fetch_phase_next = 1'b0;
                        state_next       = rx_reg[SPI_DATA_W-2] ? RD_FETCH : WR_SHIFT;
                    end
                end
            end
            RD_FETCH: begin
                if (cs_rise) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else if (!fetch_phase_reg) begin
                    fetch_phase_next = 1'b1;
                end else begin
                    tx_next    = rd_data;
                    state_next = RD_SHIFT;
                end
            end
            RD_SHIFT: begin
                if (cs_rise) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else begin
                    if (sclk_fall) begin
                        miso_next = tx_reg[SPI_DATA_W-1];
                        tx_next   = {tx_reg[SPI_DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == FRAME_LAST) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            WR_SHIFT: begin
                if (cs_rise) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else if (sclk_rise) begin
                    rx_next      = {rx_reg[SPI_DATA_W-3:0], mosi_s};
                    bit_cnt_next = bit_cnt_inc;
                    if (bit_cnt_reg == FRAME_LAST) begin
                        wdata_next = {rx_reg, mosi_s};
                        wr_en_next = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != RD_SHIFT) begin
            miso_next = 1'b0;
        end
    end

    assign rd_en     = (state_reg == RD_FETCH) && !fetch_phase_reg;
    assign wr_en     = wr_en_reg;
    assign wr_data   = wdata_reg;
    assign reg_addr  = addr_reg;
    assign frame_err = frame_err_reg;
    assign miso      = miso_reg;
    assign miso_oe   = ~cs_s;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a bit-banged SPI host at clk/8 and a
// registered-read model of the audio_gain config register.
module tb_spi_reg_bridge;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, wr_en, rd_en, frame_err;
    logic [6:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    int vec_cnt = 0;
    int miss_cnt = 0;

    int wr_seen = 0, rd_seen = 0, err_seen = 0, both_seen = 0, miso_seen = 0;
    logic [6:0] last_addr = 7'h0;
    logic [7:0] last_wdata = 8'h0;

    logic       rd_pending = 1'b0;
    logic [7:0] cfg_model = 8'h00;
    logic       use_a5 = 1'b0;

    logic [31:0] rxv;
    logic        oe_ok;

    always #5 clk = ~clk;

    spi_reg_bridge dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .reg_addr (reg_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .frame_err(frame_err)
    );

    // Config register: read data is valid only the cycle after rd_en.
    always @(posedge clk) begin
        rd_pending <= rd_en;
        if (wr_en && reg_addr == 7'h00) cfg_model <= wr_data;
    end
    assign rd_data = rd_pending ? (use_a5 ? 8'hA5 : cfg_model) : 8'h00;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen++;
            last_addr = reg_addr;
            last_wdata = wr_data;
        end
        if (rd_en) rd_seen++;
        if (frame_err) err_seen++;
        if (wr_en && rd_en) both_seen++;
        if (miso) miso_seen++;
    end

    task automatic spi_xfer(input logic [31:0] frame, input int nbits,
                            output logic [31:0] rx, output logic oe_all);
        rx = '0;
        oe_all = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = frame[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[30:0], miso};
            oe_all = oe_all & miso_oe;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("xfer frame=%h bits=%0d miso_bits=%h", frame, nbits, rx);
    endtask

    task automatic check_reset_outputs(input string tag);
        vec_cnt++; if (miso !== 1'b0) begin miss_cnt++; $display("FAIL %s miso got %b want 0", tag, miso); end
        vec_cnt++; if (miso_oe !== 1'b0) begin miss_cnt++; $display("FAIL %s miso_oe got %b want 0", tag, miso_oe); end
        vec_cnt++; if (wr_en !== 1'b0) begin miss_cnt++; $display("FAIL %s wr_en got %b want 0", tag, wr_en); end
        vec_cnt++; if (rd_en !== 1'b0) begin miss_cnt++; $display("FAIL %s rd_en got %b want 0", tag, rd_en); end
        vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL %s frame_err got %b want 0", tag, frame_err); end
        vec_cnt++; if (reg_addr !== 7'h00) begin miss_cnt++; $display("FAIL %s reg_addr got %h want 00", tag, reg_addr); end
        vec_cnt++; if (wr_data !== 8'h00) begin miss_cnt++; $display("FAIL %s wr_data got %h want 00", tag, wr_data); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_read();
        int r0, w0, e0;
        r0 = rd_seen; w0 = wr_seen; e0 = err_seen;
        use_a5 = 1'b1;
        spi_xfer(32'h8000, 16, rxv, oe_ok);
        use_a5 = 1'b0;
        vec_cnt++; if (rd_seen - r0 != 1) begin miss_cnt++; $display("FAIL read rd_en pulses got %0d want 1", rd_seen - r0); end
        vec_cnt++; if (rxv[7:0] !== 8'hA5) begin miss_cnt++; $display("FAIL read miso data got %h want a5", rxv[7:0]); end
        vec_cnt++; if (rxv[15:8] !== 8'h00) begin miss_cnt++; $display("FAIL read miso cmd phase got %h want 00", rxv[15:8]); end
        vec_cnt++; if (oe_ok !== 1'b1) begin miss_cnt++; $display("FAIL read miso_oe during frame got %b want 1", oe_ok); end
        vec_cnt++; if (wr_seen - w0 != 0) begin miss_cnt++; $display("FAIL read wr_en pulses got %0d want 0", wr_seen - w0); end
        vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("FAIL read frame_err pulses got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_write_readback();
        int w0;
        w0 = wr_seen;
        spi_xfer(32'h0015, 16, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 1) begin miss_cnt++; $display("FAIL readback wr_en pulses got %0d want 1", wr_seen - w0); end
        spi_xfer(32'h8000, 16, rxv, oe_ok);
        vec_cnt++; if (rxv[7:0] !== 8'h15) begin miss_cnt++; $display("FAIL readback miso data got %h want 15", rxv[7:0]); end
    endtask

    task automatic test_write();
        int w0, r0, e0;
        w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
        spi_xfer(32'h0015, 16, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 1) begin miss_cnt++; $display("FAIL write wr_en pulses got %0d want 1", wr_seen - w0); end
        vec_cnt++; if (last_wdata !== 8'h15) begin miss_cnt++; $display("FAIL write wr_data got %h want 15", last_wdata); end
        vec_cnt++; if (last_addr !== 7'h00) begin miss_cnt++; $display("FAIL write reg_addr got %h want 00", last_addr); end
        vec_cnt++; if (rd_seen - r0 != 0) begin miss_cnt++; $display("FAIL write rd_en pulses got %0d want 0", rd_seen - r0); end
        vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("FAIL write frame_err pulses got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_short_frame();
        int w0, e0;
        w0 = wr_seen; e0 = err_seen;
        spi_xfer(32'h0007, 11, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 0) begin miss_cnt++; $display("FAIL short wr_en pulses got %0d want 0", wr_seen - w0); end
        vec_cnt++; if (err_seen - e0 != 1) begin miss_cnt++; $display("FAIL short frame_err pulses got %0d want 1", err_seen - e0); end
        spi_xfer(32'h0001, 16, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 1) begin miss_cnt++; $display("FAIL short-recover wr_en pulses got %0d want 1", wr_seen - w0); end
        vec_cnt++; if (last_wdata !== 8'h01) begin miss_cnt++; $display("FAIL short-recover wr_data got %h want 01", last_wdata); end
        vec_cnt++; if (err_seen - e0 != 1) begin miss_cnt++; $display("FAIL short-recover frame_err pulses got %0d want 1", err_seen - e0); end
    endtask

    task automatic test_long_frame();
        int w0, m0, e0;
        w0 = wr_seen; m0 = miso_seen; e0 = err_seen;
        spi_xfer(32'h003CA, 20, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 1) begin miss_cnt++; $display("FAIL long wr_en pulses got %0d want 1", wr_seen - w0); end
        vec_cnt++; if (last_wdata !== 8'h3C) begin miss_cnt++; $display("FAIL long wr_data got %h want 3c", last_wdata); end
        vec_cnt++; if (miso_seen - m0 != 0) begin miss_cnt++; $display("FAIL long miso high cycles got %0d want 0", miso_seen - m0); end
        vec_cnt++; if (rxv !== 32'h0) begin miss_cnt++; $display("FAIL long host miso bits got %h want 0", rxv); end
        vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("FAIL long frame_err pulses got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wr_seen;
        spi_xfer(32'h55C3, 16, rxv, oe_ok);
        vec_cnt++; if (last_addr !== 7'h55) begin miss_cnt++; $display("FAIL b2b reg_addr got %h want 55", last_addr); end
        vec_cnt++; if (last_wdata !== 8'hC3) begin miss_cnt++; $display("FAIL b2b wr_data got %h want c3", last_wdata); end
        spi_xfer(32'h005A, 16, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 2) begin miss_cnt++; $display("FAIL b2b wr_en pulses got %0d want 2", wr_seen - w0); end
        vec_cnt++; if (last_wdata !== 8'h5A) begin miss_cnt++; $display("FAIL b2b second wr_data got %h want 5a", last_wdata); end
    endtask

    task automatic test_reset_mid_frame();
        int w0, e0;
        logic [15:0] frame;
        frame = 16'h007F;
        w0 = wr_seen; e0 = err_seen;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 15; i >= 0; i--) begin
            mosi = frame[i];
            repeat (4) @(negedge clk);
            if (i == 4) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_reset_outputs("midreset");
            end
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("xfer frame=%h bits=16 reset during bit 12", frame);
        vec_cnt++; if (wr_seen - w0 != 0) begin miss_cnt++; $display("FAIL midreset wr_en pulses got %0d want 0", wr_seen - w0); end
        vec_cnt++; if (err_seen - e0 != 0) begin miss_cnt++; $display("FAIL midreset frame_err pulses got %0d want 0", err_seen - e0); end
        spi_xfer(32'h0042, 16, rxv, oe_ok);
        vec_cnt++; if (wr_seen - w0 != 1) begin miss_cnt++; $display("FAIL midreset-recover wr_en pulses got %0d want 1", wr_seen - w0); end
        vec_cnt++; if (last_wdata !== 8'h42) begin miss_cnt++; $display("FAIL midreset-recover wr_data got %h want 42", last_wdata); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_readback();
        test_write();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_reset_mid_frame();
        vec_cnt++;
        if (both_seen != 0) begin
            miss_cnt++;
            $display("FAIL exclusive wr_en&rd_en cycles got %0d want 0", both_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
